systolic_fir: RTL and testbench

Parametrised, valid-gated systolic FIR filter with a run-time reloadable coefficient bank and a rounded, width-reduced output stage. It replaces the fixed 7-tap, 32-bit filter in the signal path between the sample source and downstream consumers. Taps, data width, coefficient width, accumulator width and output scaling are all generic. The array advances only on valid samples.

---
 rtl/systolic_fir_pkg.sv | 52 +++++
 rtl/fir_pe.sv | 31 +++
 rtl/systolic_fir.sv | 121 ++++++++++++
 tb/tb_systolic_fir.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_fir_pkg.sv
// Shared definitions for the systolic FIR: reset coefficient table,
// compile-time log2 helper and the output round/reduce function.
package systolic_fir_pkg;

   localparam int MAX_TAPS = 64;

   // Coefficients loaded into both banks on reset; taps past 6 start at zero
   localparam int DEFAULT_COEF [MAX_TAPS] = '{0: 4, 1: 18, 2: 47, 3: 62, 4: 47, 5: 18, 6: 4, default: 0};

   typedef struct packed {
      logic signed [63:0] value;
      logic               sat;
   } scaled_t;

   // Address width for n entries, never less than one bit
   function automatic int clog2(input int n);
      int r;
      r = 1;
      for (int i = 1; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

   // Round half up by 'shift', then clip to out_w bits when sat_en is set.
   // Without sat_en the caller keeps the low out_w bits (two's-complement wrap).
   // Accumulators wider than 64 bits are not supported by this path.
   function automatic scaled_t scale_out(input logic signed [63:0] acc, input int shift,
                                         input int out_w, input bit sat_en);
      scaled_t            r;
      logic signed [63:0] v;
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      v = acc;
      if (shift > 0) v = (v + (64'sd1 <<< (shift - 1))) >>> shift;
      hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      r.value = v;
      r.sat   = 1'b0;
      if (sat_en) begin
         if (v > hi) begin
            r.value = hi;
            r.sat   = 1'b1;
         end else if (v < lo) begin
            r.value = lo;
            r.sat   = 1'b1;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/fir_pe.sv
// One processing element of the transposed FIR: z_out <= z_in + coef * x,
// advancing only while en is high.
module fir_pe #(
   parameter int DATA_W = 16,
   parameter int COEF_W = 16,
   parameter int ACC_W  = 40
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic signed [COEF_W-1:0] coef,
   input  logic signed [DATA_W-1:0] x,
   input  logic signed [ACC_W-1:0]  z_in,
   output logic signed [ACC_W-1:0]  z_out
);

   localparam int PROD_W = DATA_W + COEF_W;

   logic signed [PROD_W-1:0] prod;
   logic signed [ACC_W-1:0]  prod_ext;

   assign prod     = PROD_W'(coef) * PROD_W'(x);
   assign prod_ext = ACC_W'(prod);

   // Partial-sum register; the add wraps modulo 2^ACC_W
   always_ff @(posedge clk or posedge rst) begin
      if (rst) z_out <= '0;
      else if (en) z_out <= z_in + prod_ext;
   end

endmodule

// File: rtl/systolic_fir.sv
// Valid-gated transposed systolic FIR with shadow/active coefficient banks
// and a rounded, width-reduced output register.
// Define SYSTOLIC_FIR_SAT_EN to clip the output (and report out_sat);
// otherwise the output wraps and out_sat is tied low.
module systolic_fir
   import systolic_fir_pkg::*;
#(
   parameter int TAPS      = 7,
   parameter int DATA_W    = 16,
   parameter int COEF_W    = 16,
   parameter int ACC_W     = 40,
   parameter int OUT_SHIFT = 0,
   parameter int OUT_W     = 16,
   localparam int AW       = clog2(TAPS)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   input  logic signed [DATA_W-1:0] in_data,
   input  logic                     coef_we,
   input  logic [AW-1:0]            coef_addr,
   input  logic signed [COEF_W-1:0] coef_data,
   input  logic                     coef_commit,
   output logic                     out_valid,
   output logic signed [OUT_W-1:0]  out_data,
   output logic                     out_sat
);

`ifdef SYSTOLIC_FIR_SAT_EN
   localparam bit SAT_EN = 1'b1;
`else
   localparam bit SAT_EN = 1'b0;
`endif

   localparam int PROD_W = DATA_W + COEF_W;

   logic signed [DATA_W-1:0] x_r;
   logic                     v_r;
   logic signed [COEF_W-1:0] shadow_coef [TAPS];
   logic signed [COEF_W-1:0] active_coef [TAPS];
   logic signed [ACC_W-1:0]  z [1:TAPS-1];
   logic signed [PROD_W-1:0] prod0;
   logic signed [ACC_W-1:0]  sum0;
   scaled_t                  scaled;
   logic                     unused_bits;

   // Stage 1: capture the sample and its valid flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x_r <= '0;
         v_r <= 1'b0;
      end else begin
         v_r <= in_valid;
         if (in_valid) x_r <= in_data;
      end
   end

   // Coefficient banks: commit copies the pre-write shadow value
   for (genvar gi = 0; gi < TAPS; gi++) begin : g_coef
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            shadow_coef[gi] <= COEF_W'(DEFAULT_COEF[gi]);
            active_coef[gi] <= COEF_W'(DEFAULT_COEF[gi]);
         end else begin
            if (coef_we && coef_addr == AW'(gi)) shadow_coef[gi] <= coef_data;
            if (coef_commit) active_coef[gi] <= shadow_coef[gi];
         end
      end
   end

   // PE k holds z[k]; the last PE starts its chain from zero
   for (genvar gi = 1; gi < TAPS; gi++) begin : g_pe
      logic signed [ACC_W-1:0] z_in;
      if (gi == TAPS - 1) begin : g_last
         assign z_in = '0;
      end else begin : g_mid
         assign z_in = z[gi+1];
      end
      fir_pe #(
         .DATA_W(DATA_W),
         .COEF_W(COEF_W),
         .ACC_W (ACC_W)
      ) u_pe (
         .clk  (clk),
         .rst  (rst),
         .en   (v_r),
         .coef (active_coef[gi]),
         .x    (x_r),
         .z_in (z_in),
         .z_out(z[gi])
      );
   end

   // Tap 0 lives in the output stage rather than in a PE
   assign prod0       = PROD_W'(active_coef[0]) * PROD_W'(x_r);
   assign sum0        = z[1] + ACC_W'(prod0);
   assign scaled      = scale_out(64'(sum0), OUT_SHIFT, OUT_W, SAT_EN);
   assign unused_bits = ^{scaled.value[63:OUT_W], scaled.sat};

   // Stage 2: registered result; data holds while no sample is in flight
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         out_valid <= v_r;
         if (v_r) out_data <= scaled.value[OUT_W-1:0];
      end
   end

`ifdef SYSTOLIC_FIR_SAT_EN
   // Clip flag travels with the result it describes
   always_ff @(posedge clk or posedge rst) begin
      if (rst) out_sat <= 1'b0;
      else if (v_r) out_sat <= scaled.sat;
   end
`else
   assign out_sat = 1'b0;
`endif

endmodule

// File: tb/tb_systolic_fir.sv
// Directed bench for systolic_fir with default parameters.
module tb_systolic_fir;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               in_valid = 1'b0;
   logic signed [15:0] in_data = '0;
   logic               coef_we = 1'b0;
   logic [2:0]         coef_addr = '0;
   logic signed [15:0] coef_data = '0;
   logic               coef_commit = 1'b0;
   logic               out_valid;
   logic signed [15:0] out_data;
   logic               out_sat;

   int checks = 0;
   int passed = 0;

   always #5 clk = ~clk;

   systolic_fir dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .coef_we    (coef_we),
      .coef_addr  (coef_addr),
      .coef_data  (coef_data),
      .coef_commit(coef_commit),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_sat    (out_sat)
   );

   // Drive one cycle of inputs, then sample outputs 1 time unit after the edge
   task automatic cycle(input bit v, input int x, input bit we, input int a, input int c,
                        input bit cm, output logic ov, output logic signed [15:0] od,
                        output logic os);
      in_valid    = v;
      in_data     = 16'(x);
      coef_we     = we;
      coef_addr   = 3'(a);
      coef_data   = 16'(c);
      coef_commit = cm;
      @(posedge clk);
      #1;
      ov          = out_valid;
      od          = out_data;
      os          = out_sat;
      in_valid    = 1'b0;
      coef_we     = 1'b0;
      coef_commit = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_data !== 16'sd0 || out_sat !== 1'b0)
         $display("FAIL reset valid=%b data=%0d sat=%b, expected 0/0/0", out_valid, out_data, out_sat);
      else passed++;
      $display("reset: valid=%b data=%0d sat=%b", out_valid, out_data, out_sat);
      rst = 1'b0;
   endtask

   // Impulse through default bank; output k appears one loop step after its drive
   task automatic test_impulse(input string tag, input bit pre_reset);
      int exp [7] = '{4, 18, 47, 62, 47, 18, 4};
      logic ov, os;
      logic signed [15:0] od;
      if (pre_reset) do_reset();
      for (int i = 0; i < 9; i++) begin
         cycle(i < 7, (i == 0) ? 1 : 0, 1'b0, 0, 0, 1'b0, ov, od, os);
         checks++;
         if (i >= 1 && i <= 7) begin
            if (ov !== 1'b1 || od !== 16'(exp[i-1]))
               $display("FAIL %s[%0d] valid=%b data=%0d, expected valid=1 data=%0d", tag, i - 1, ov, od, exp[i-1]);
            else passed++;
            $display("%s: y[%0d]=%0d", tag, i - 1, od);
         end else begin
            if (ov !== 1'b0) $display("FAIL %s_idle[%0d] valid=%b, expected 0", tag, i, ov);
            else passed++;
         end
      end
   endtask

   task automatic test_step();
      int exp [9] = '{400, 2200, 6900, 13100, 17800, 19600, 20000, 20000, 20000};
      logic ov, os;
      logic signed [15:0] od;
      do_reset();
      for (int i = 0; i < 10; i++) begin
         cycle(i < 9, 100, 1'b0, 0, 0, 1'b0, ov, od, os);
         if (i >= 1) begin
            checks++;
            if (ov !== 1'b1 || od !== 16'(exp[i-1]) || os !== 1'b0)
               $display("FAIL step[%0d] valid=%b data=%0d sat=%b, expected valid=1 data=%0d sat=0", i - 1, ov, od, os, exp[i-1]);
            else passed++;
            $display("step: y[%0d]=%0d", i - 1, od);
         end
      end
   endtask

   // Impulse with three idle cycles between samples
   task automatic test_gapped();
      int exp [7] = '{4, 18, 47, 62, 47, 18, 4};
      logic ov, os, ev;
      logic signed [15:0] od;
      do_reset();
      for (int i = 0; i < 26; i++) begin
         cycle((i % 4 == 0) && (i / 4 < 7), (i == 0) ? 1 : 0, 1'b0, 0, 0, 1'b0, ov, od, os);
         ev = (i >= 1) && ((i - 1) % 4 == 0) && ((i - 1) / 4 < 7);
         checks++;
         if (ov !== ev) $display("FAIL gapped_valid[%0d] valid=%b, expected %b", i, ov, ev);
         else passed++;
         if (ev) begin
            checks++;
            if (od !== 16'(exp[(i-1)/4]))
               $display("FAIL gapped[%0d] data=%0d, expected %0d", (i - 1) / 4, od, exp[(i-1)/4]);
            else passed++;
            $display("gapped: y[%0d]=%0d", (i - 1) / 4, od);
         end
      end
   endtask

   // Load all ones (plus an out-of-range write), commit while a sample is in flight
   task automatic test_reload();
      int exp [9] = '{4, 19, 49, 65, 51, 23, 10, 7, 7};
      logic ov, os;
      logic signed [15:0] od;
      do_reset();
      for (int a = 0; a < 8; a++) cycle(1'b0, 0, 1'b1, a, (a == 7) ? 99 : 1, 1'b0, ov, od, os);
      for (int i = 0; i < 10; i++) begin
         cycle(i < 9, 1, 1'b0, 0, 0, i == 1, ov, od, os);
         if (i >= 1) begin
            checks++;
            if (ov !== 1'b1 || od !== 16'(exp[i-1]))
               $display("FAIL reload[%0d] valid=%b data=%0d, expected valid=1 data=%0d", i - 1, ov, od, exp[i-1]);
            else passed++;
            $display("reload: y[%0d]=%0d", i - 1, od);
         end
      end
   endtask

   // Write and commit in the same cycle: commit must take the old shadow value
   task automatic test_we_commit_collision();
      logic ov, os;
      logic signed [15:0] od;
      cycle(1'b0, 0, 1'b1, 0, 5, 1'b1, ov, od, os);
      for (int i = 0; i < 8; i++) cycle(1'b1, 0, 1'b0, 0, 0, 1'b0, ov, od, os);
      cycle(1'b1, 1, 1'b0, 0, 0, 1'b0, ov, od, os);
      cycle(1'b1, 0, 1'b0, 0, 0, 1'b0, ov, od, os);
      checks++;
      if (ov !== 1'b1 || od !== 16'sd1)
         $display("FAIL collision_old valid=%b data=%0d, expected valid=1 data=1", ov, od);
      else passed++;
      $display("collision: w0 before second commit=%0d", od);
      cycle(1'b0, 0, 1'b0, 0, 0, 1'b1, ov, od, os);
      for (int i = 0; i < 7; i++) cycle(1'b1, 0, 1'b0, 0, 0, 1'b0, ov, od, os);
      cycle(1'b1, 1, 1'b0, 0, 0, 1'b0, ov, od, os);
      cycle(1'b1, 0, 1'b0, 0, 0, 1'b0, ov, od, os);
      checks++;
      if (ov !== 1'b1 || od !== 16'sd5)
         $display("FAIL collision_new valid=%b data=%0d, expected valid=1 data=5", ov, od);
      else passed++;
      $display("collision: w0 after second commit=%0d", od);
      cycle(1'b1, 0, 1'b0, 0, 0, 1'b0, ov, od, os);
      checks++;
      if (ov !== 1'b1 || od !== 16'sd1)
         $display("FAIL collision_w1 valid=%b data=%0d, expected valid=1 data=1", ov, od);
      else passed++;
      $display("collision: w1=%0d", od);
   endtask

   task automatic test_saturation();
      logic ov, os;
      logic signed [15:0] od;
`ifdef SYSTOLIC_FIR_SAT_EN
      int  exp_d = 32767;
      bit  exp_s = 1'b1;
`else
      int  exp_d = -200;
      bit  exp_s = 1'b0;
`endif
      do_reset();
      for (int i = 0; i < 11; i++) begin
         cycle(i < 10, 32767, 1'b0, 0, 0, 1'b0, ov, od, os);
         if (i >= 7) begin
            checks++;
            if (ov !== 1'b1 || od !== 16'(exp_d) || os !== exp_s)
               $display("FAIL saturation[%0d] valid=%b data=%0d sat=%b, expected valid=1 data=%0d sat=%b", i - 1, ov, od, os, exp_d, exp_s);
            else passed++;
            $display("saturation: y[%0d]=%0d sat=%b", i - 1, od, os);
         end
      end
   endtask

   // Reset asserted mid-cycle during a step; outputs clear at once, nothing leaks out
   task automatic test_reset_midstream();
      logic ov, os;
      logic signed [15:0] od;
      do_reset();
      for (int i = 0; i < 5; i++) cycle(1'b1, 100, 1'b0, 0, 0, 1'b0, ov, od, os);
      in_valid = 1'b1;
      in_data  = 16'sd100;
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_data !== 16'sd0 || out_sat !== 1'b0)
         $display("FAIL midreset valid=%b data=%0d sat=%b, expected 0/0/0", out_valid, out_data, out_sat);
      else passed++;
      $display("midreset: valid=%b data=%0d", out_valid, out_data);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, 0, 1'b0, 0, 0, 1'b0, ov, od, os);
         checks++;
         if (ov !== 1'b0) $display("FAIL midreset_leak[%0d] valid=%b, expected 0", i, ov);
         else passed++;
      end
      test_impulse("impulse_after_reset", 1'b0);
   endtask

   initial begin
      test_reset();
      test_impulse("impulse", 1'b1);
      test_step();
      test_gapped();
      test_reload();
      test_we_commit_collision();
      test_saturation();
      test_reset_midstream();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired, checks=%0d passed=%0d", checks, passed);
      $fatal(1, "watchdog");
   end

endmodule
